// File: rtl/mux8.sv
// Registered one-hot AND-OR mux over eight channels.
// Flags whether each captured select was one-hot.
module mux8 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] ch8,
   input  logic [WIDTH-1:0] ch7,
   input  logic [WIDTH-1:0] ch6,
   input  logic [WIDTH-1:0] ch5,
   input  logic [WIDTH-1:0] ch4,
   input  logic [WIDTH-1:0] ch3,
   input  logic [WIDTH-1:0] ch2,
   input  logic [WIDTH-1:0] ch1,
   input  logic [7:0]       sel,
   output logic [WIDTH-1:0] y,
   output logic             valid,
   output logic             sel_err
);

   logic [WIDTH-1:0] ch [8];
   logic [WIDTH-1:0] mux_val;
   logic             one_hot;

   assign ch[0] = ch1;
   assign ch[1] = ch2;
   assign ch[2] = ch3;
   assign ch[3] = ch4;
   assign ch[4] = ch5;
   assign ch[5] = ch6;
   assign ch[6] = ch7;
   assign ch[7] = ch8;

   // No priority: multi-hot selects OR their channels together.
   always_comb begin
      mux_val = '0;
      for (int i = 0; i < 8; i++) begin
         mux_val = mux_val | (ch[i] & {WIDTH{sel[i]}});
      end
   end

   assign one_hot = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y       <= '0;
         valid   <= 1'b0;
         sel_err <= 1'b0;
      end else if (en) begin
         y       <= mux_val;
         valid   <= one_hot;
         sel_err <= !one_hot;
      end
   end

endmodule

// File: tb/tb_mux8.sv
// Directed bench for mux8: scoreboard queue of expected captures,
// immediate assertions at each sample point.
module tb_mux8;

   typedef struct packed {
      logic [15:0] y;
      logic        v;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] ch [8];
   logic [7:0]  sel;
   logic [15:0] y;
   logic        valid;
   logic        sel_err;

   exp_t sb [$];
   exp_t held;
   int   n_assert = 0;
   int   n_fail = 0;

   mux8 #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .ch8(ch[7]), .ch7(ch[6]), .ch6(ch[5]), .ch5(ch[4]),
      .ch4(ch[3]), .ch3(ch[2]), .ch2(ch[1]), .ch1(ch[0]),
      .sel(sel), .y(y), .valid(valid), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] s);
      exp_t r;
      r.y = '0;
      for (int i = 0; i < 8; i++)
         if (s[i]) r.y = r.y | ch[i];
      r.v = ($countones(s) == 1);
      r.e = !r.v;
      return r;
   endfunction

   // One clock step; enabled steps go through the scoreboard.
   task automatic step(input string tag, input logic [7:0] s,
                       input logic e);
      sel = s;
      en  = e;
      if (e) sb.push_back(model(s));
      @(posedge clk);
      #1;
      if (e) begin
         if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            held = sb.pop_front();
         end
      end
      check({tag, "_y"}, {16'd0, y}, {16'd0, held.y});
      check({tag, "_valid"}, {31'd0, valid}, {31'd0, held.v});
      check({tag, "_sel_err"}, {31'd0, sel_err}, {31'd0, held.e});
      check({tag, "_excl"}, {31'd0, valid & sel_err}, 32'd0);
   endtask

   task automatic spec_channels();
      ch[7] = 16'b0010000000000000;
      ch[6] = 16'b0001010101010101;
      ch[5] = 16'b1001100100111100;
      ch[4] = 16'b1101010010100010;
      ch[3] = 16'b0100101001010111;
      ch[2] = 16'b0010000000000000;
      ch[1] = 16'b0001010101010101;
      ch[0] = 16'b1001100100111100;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      sel   = '0;
      held  = '0;
      for (int i = 0; i < 8; i++) ch[i] = 16'hFFFF;
      #1;
      check("reset_y", {16'd0, y}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_sel_err", {31'd0, sel_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      spec_channels();

      step("sel08", 8'b00001000, 1'b1);
      check("sel08_lit", {16'd0, y}, {16'd0, 16'b0100101001010111});
      check("sel08_v", {30'd0, valid, sel_err}, 32'b10);

      step("sel09", 8'b00001001, 1'b1);
      check("sel09_lit", {16'd0, y}, {16'd0, 16'b1101101101111111});
      check("sel09_v", {30'd0, valid, sel_err}, 32'b01);

      step("sel00", 8'b00000000, 1'b1);
      check("sel00_lit", {16'd0, y}, 32'd0);
      check("sel00_v", {30'd0, valid, sel_err}, 32'b01);

      for (int i = 0; i < 8; i++) begin
         logic [7:0] s;
         s = 8'd1 << i;
         step($sformatf("walk%0d", i), s, 1'b1);
         check($sformatf("walk%0d_ch", i), {16'd0, y}, {16'd0, ch[i]});
         check($sformatf("walk%0d_v", i), {31'd0, valid}, 32'd1);
      end

      for (int i = 0; i < 4; i++) begin
         logic [7:0] s;
         s = 8'($urandom_range(0, 255));
         s[i] = 1'b1;
         s[i + 4] = 1'b1;
         step($sformatf("multi%0d", i), s, 1'b1);
      end

      step("hold_cap", 8'b00001000, 1'b1);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) ch[i] = 16'($urandom);
         step($sformatf("hold%0d", k), 8'($urandom), 1'b0);
         check($sformatf("hold%0d_lit", k), {16'd0, y},
               {16'd0, 16'b0100101001010111});
      end

      spec_channels();
      step("pre_rst", 8'b00000001, 1'b1);
      check("pre_rst_nz", {31'd0, y != 16'd0}, 32'd1);
      sel = 8'b00000010;
      en  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_y", {16'd0, y}, 32'd0);
      check("async_flags", {30'd0, valid, sel_err}, 32'd0);
      held = '0;
      @(posedge clk);
      #1;
      check("rst_hold_y", {16'd0, y}, 32'd0);
      check("rst_hold_flags", {30'd0, valid, sel_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_dis", 8'b00000010, 1'b0);
      step("post_rst_cap", 8'b00000010, 1'b1);
      check("post_rst_lit", {16'd0, y}, {16'd0, 16'b0001010101010101});

      check("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mux8.md
MUX8 -- requirements
Module: mux8

Interface
REQ-001 Parameter WIDTH, default 16, data width of every channel and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  capture enable; when high, the output registers load on the next clk edge.
REQ-005 ch8  input  WIDTH  data channel 8.
REQ-006 ch7  input  WIDTH  data channel 7.
REQ-007 ch6  input  WIDTH  data channel 6.
REQ-008 ch5  input  WIDTH  data channel 5.
REQ-009 ch4  input  WIDTH  data channel 4.
REQ-010 ch3  input  WIDTH  data channel 3.
REQ-011 ch2  input  WIDTH  data channel 2.
REQ-012 ch1  input  WIDTH  data channel 1.
REQ-013 sel  input  8  one-hot select; sel[i] selects channel i+1 (sel[0] selects ch1, sel[7] selects ch8).
REQ-014 y  output  WIDTH  registered selected data.
REQ-015 valid  output  1  high when y holds a result captured with exactly one sel bit set.
REQ-016 sel_err  output  1  high when the last captured sel was not one-hot (all zero or more than one bit set).
REQ-017 Port order is ch8..ch1, then sel, then y; clk, rst_n and en precede them.

Function
REQ-018 Combinational select value: bitwise OR over i of (channel i+1 AND replicated sel[i]), i.e. an AND-OR one-hot mux.
REQ-019 sel = 0 gives a combinational select value of all zeros.
REQ-020 Multi-hot sel gives the bitwise OR of all selected channels; there is no priority among set bits.
REQ-021 One-hot check: sel is one-hot exactly when sel != 0 and (sel AND (sel-1)) == 0.
REQ-022 On a rising clk with en=1:
- y <= the combinational select value;
- valid <= one-hot check;
- sel_err <= NOT one-hot check.
REQ-023 On a rising clk with en=0, y, valid and sel_err hold their values.
REQ-024 Latency is exactly one clk from the sampled inputs (en, sel, channels) to y, valid and sel_err.
REQ-025 Channel or sel changes between edges have no effect on the outputs until the next enabled edge.
REQ-026 valid and sel_err are never both high.
REQ-027 No combinational path from any input to y, valid or sel_err.

Reset
REQ-028 While rst_n=0, y=0, valid=0 and sel_err=0, asserted immediately without waiting for clk.
REQ-029 Reset asserted mid-operation discards the pending capture.
REQ-030 The first enabled edge after rst_n rises captures normally.

Verification
REQ-031 Channel values for REQ-032 to REQ-034:
- ch8=0010000000000000, ch7=0001010101010101, ch6=1001100100111100, ch5=1101010010100010;
- ch4=0100101001010111, ch3=0010000000000000, ch2=0001010101010101, ch1=1001100100111100.
REQ-032 sel=00001000, en=1, one edge -> y=0100101001010111, valid=1, sel_err=0.
REQ-033 sel=00001001, en=1, one edge -> y=1101101101111111, valid=0, sel_err=1.
REQ-034 sel=00000000, en=1, one edge -> y=0, valid=0, sel_err=1.
REQ-035 Walking one-hot sel=00000001..10000000 -> y equals ch1..ch8 respectively, each one edge later, with valid=1.
REQ-036 Capture ch4, then set en=0, change sel and all channels, and clock 3 edges -> y stays 0100101001010111.
REQ-037 With y nonzero, pulse rst_n low between clk edges -> y, valid and sel_err go to 0 at once and stay 0 until the next enabled edge after release.
